// File: rtl/dtv1_macc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dtv1_macc_ctrl
//  Purpose  : Cycle-by-cycle sequencer for the DTV1 MACC array (MAC / DOT jobs)
//  Revision : 1.0
// ============================================================================
module dtv1_macc_ctrl #(
    parameter int NUM_PE = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cfg_start,
    input  logic              cfg_mode,
    input  logic [CNT_W-1:0]  cfg_len,
    input  logic [CNT_W-1:0]  cfg_tiles,
    input  logic              cfg_opsel,
    input  logic              cfg_bias_en,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [NUM_PE-1:0] en_mul,
    output logic [NUM_PE-1:0] en_add,
    output logic              en_acc,
    output logic              mul_mux_sel,
    output logic              add_mux0_sel,
    output logic [1:0]        add_mux1_sel,
    output logic [1:0]        acc_mux_sel,
    output logic              busy,
    output logic              out_valid,
    output logic              done
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_MUL    = 3'd1;
    localparam logic [2:0] c_DRAIN  = 3'd2;
    localparam logic [2:0] c_REDUCE = 3'd3;
    localparam logic [2:0] c_ACC    = 3'd4;
    localparam logic [2:0] c_OUT    = 3'd5;
    localparam logic [2:0] c_DONEZ  = 3'd6;

    localparam int                c_K_W      = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam logic [c_K_W-1:0]  c_K_FIRST  = 1;
    localparam logic [c_K_W-1:0]  c_K_LAST   = c_K_W'(NUM_PE - 1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE  = 1;
    localparam logic [NUM_PE-1:0] c_LANE0    = 1;
    localparam bit                c_SINGLE   = (NUM_PE == 1);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic             r_mode;
    logic             r_opsel;
    logic             r_bias;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_tiles;
    logic [CNT_W-1:0] r_beat_cnt;
    logic [CNT_W-1:0] r_tile_cnt;
    logic [c_K_W-1:0] r_red_k;
    logic             r_add_vld;
    logic             r_add_first;

    logic             w_accept;
    logic             w_last_beat;
    logic             w_first_tile;
    logic             w_last_tile;
    logic [1:0]       w_add_sel;

    assign w_accept     = (r_state == c_MUL) && in_valid;
    assign w_last_beat  = (r_beat_cnt == r_len - c_CNT_ONE);
    assign w_first_tile = (r_tile_cnt == '0);
    assign w_last_tile  = (r_tile_cnt == r_tiles - c_CNT_ONE);
    // The add stage trails the multiply stage by one cycle, so the seed
    // choice follows the beat that was accepted in the previous cycle.
    assign w_add_sel    = r_add_first ? {1'b0, r_bias} : 2'b10;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:   if (cfg_start) w_next = ((cfg_len == '0) || (cfg_tiles == '0)) ? c_DONEZ : c_MUL;
            c_MUL:    if (w_accept && w_last_beat) w_next = c_DRAIN;
            c_DRAIN:  w_next = !r_mode ? c_OUT : (c_SINGLE ? c_ACC : c_REDUCE);
            c_REDUCE: if (r_red_k == c_K_LAST) w_next = c_ACC;
            c_ACC:    w_next = w_last_tile ? c_OUT : c_MUL;
            c_OUT:    w_next = (r_mode || w_last_tile) ? c_IDLE : c_MUL;
            c_DONEZ:  w_next = c_IDLE;
            default:  w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mode      <= 1'b0;
            r_opsel     <= 1'b0;
            r_bias      <= 1'b0;
            r_len       <= '0;
            r_tiles     <= '0;
            r_beat_cnt  <= '0;
            r_tile_cnt  <= '0;
            r_red_k     <= '0;
            r_add_vld   <= 1'b0;
            r_add_first <= 1'b0;
        end else begin
            r_add_vld   <= w_accept;
            r_add_first <= w_accept && (r_beat_cnt == '0);
            if ((r_state == c_IDLE) && cfg_start) begin
                r_mode  <= cfg_mode;
                r_opsel <= cfg_opsel;
                r_bias  <= cfg_bias_en;
                r_len   <= cfg_len;
                r_tiles <= cfg_tiles;
            end
            if ((w_next == c_MUL) && (r_state != c_MUL)) begin
                r_beat_cnt <= '0;
            end else if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + c_CNT_ONE;
            end
            if (r_state == c_DRAIN) begin
                r_red_k <= c_K_FIRST;
            end else if (r_state == c_REDUCE) begin
                r_red_k <= r_red_k + c_K_FIRST;
            end
            if (w_next == c_IDLE) begin
                r_tile_cnt <= '0;
            end else if ((r_state == c_ACC) || ((r_state == c_OUT) && !r_mode)) begin
                r_tile_cnt <= r_tile_cnt + c_CNT_ONE;
            end
        end
    end

    always_comb begin
        in_ready     = 1'b0;
        en_mul       = '0;
        en_add       = '0;
        en_acc       = 1'b0;
        add_mux0_sel = 1'b0;
        add_mux1_sel = 2'b00;
        acc_mux_sel  = 2'b00;
        out_valid    = 1'b0;
        done         = 1'b0;
        busy         = (r_state != c_IDLE);
        mul_mux_sel  = (r_state != c_IDLE) ? r_opsel : 1'b0;
        case (r_state)
            c_MUL: begin
                in_ready = 1'b1;
                en_mul   = w_accept ? '1 : '0;
                if (r_add_vld) begin
                    en_add       = '1;
                    add_mux1_sel = w_add_sel;
                end
            end
            c_DRAIN: begin
                en_add       = '1;
                add_mux1_sel = w_add_sel;
            end
            c_REDUCE: begin
                en_add       = c_LANE0 << r_red_k;
                add_mux0_sel = 1'b1;
                add_mux1_sel = 2'b10;
            end
            c_ACC: begin
                en_acc      = 1'b1;
                acc_mux_sel = w_first_tile ? {1'b0, r_bias} : 2'b10;
            end
            c_OUT: begin
                out_valid = 1'b1;
                done      = r_mode || w_last_tile;
            end
            c_DONEZ: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dtv1_macc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dtv1_macc_ctrl
//  Purpose  : Scoreboard bench for dtv1_macc_ctrl against a job-timeline model
//  Revision : 1.0
// ============================================================================
module tb_dtv1_macc_ctrl;

    localparam int NP = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_mode = 1'b0;
    logic [CW-1:0] cfg_len = '0;
    logic [CW-1:0] cfg_tiles = '0;
    logic          cfg_opsel = 1'b0;
    logic          cfg_bias_en = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NP-1:0] en_mul;
    logic [NP-1:0] en_add;
    logic          en_acc;
    logic          mul_mux_sel;
    logic          add_mux0_sel;
    logic [1:0]    add_mux1_sel;
    logic [1:0]    acc_mux_sel;
    logic          busy;
    logic          out_valid;
    logic          done;

    always #5 clk = ~clk;

    dtv1_macc_ctrl #(.NUM_PE(NP), .CNT_W(CW)) u_dut (
        .clk(clk), .rstn(rstn),
        .cfg_start(cfg_start), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
        .cfg_tiles(cfg_tiles), .cfg_opsel(cfg_opsel), .cfg_bias_en(cfg_bias_en),
        .in_valid(in_valid), .in_ready(in_ready),
        .en_mul(en_mul), .en_add(en_add), .en_acc(en_acc),
        .mul_mux_sel(mul_mux_sel), .add_mux0_sel(add_mux0_sel),
        .add_mux1_sel(add_mux1_sel), .acc_mux_sel(acc_mux_sel),
        .busy(busy), .out_valid(out_valid), .done(done)
    );

    typedef struct packed {
        logic          in_ready;
        logic [NP-1:0] en_mul;
        logic [NP-1:0] en_add;
        logic          en_acc;
        logic          mul_sel;
        logic          mux0;
        logic [1:0]    mux1;
        logic [1:0]    accs;
        logic          busy;
        logic          outv;
        logic          done;
    } rec_t;

    rec_t sb_q[$];
    rec_t m_rec[$];
    bit   m_v[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    function automatic rec_t actual();
        rec_t a;
        a.in_ready = in_ready;   a.en_mul = en_mul;     a.en_add = en_add;
        a.en_acc   = en_acc;     a.mul_sel = mul_mux_sel; a.mux0 = add_mux0_sel;
        a.mux1     = add_mux1_sel; a.accs = acc_mux_sel; a.busy = busy;
        a.outv     = out_valid;  a.done = done;
        return a;
    endfunction

    task automatic chk(input string nm, input rec_t act, input rec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
        end
    endtask

    // Every active cycle pops one expected control vector; idle cycles expect all zero.
    task automatic monitor_loop();
        rec_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                e = '0;
                if (sb_q.size() > 0) e = sb_q.pop_front();
                chk("ctrl", actual(), e);
            end
        end
    endtask

    function automatic rec_t base(input bit opsel);
        rec_t r;
        r = '0;
        r.busy = 1'b1;
        r.mul_sel = opsel;
        return r;
    endfunction

    // Builds the expected per-cycle timeline of a job, starting the cycle after cfg_start.
    task automatic build_job(input bit mode, input int len, input int tiles, input bit opsel,
                             input bit bias, input int stall_pct, input int stall_at);
        rec_t          r;
        bit            v;
        bit            pend;
        bit            pend_first;
        int            b;
        logic [NP-1:0] lane;
        m_rec.delete();
        m_v.delete();
        if (len == 0 || tiles == 0) begin
            r = base(opsel);
            r.done = 1'b1;
            m_rec.push_back(r);
            m_v.push_back(1'($urandom_range(1)));
            return;
        end
        for (int t = 0; t < tiles; t++) begin
            pend = 1'b0;
            pend_first = 1'b0;
            b = 0;
            while (b < len) begin
                if (m_rec.size() + 1 == stall_at) v = 1'b0;
                else v = ($urandom_range(99) >= stall_pct);
                r = base(opsel);
                r.in_ready = 1'b1;
                if (v) r.en_mul = '1;
                if (pend) begin
                    r.en_add = '1;
                    r.mux1 = pend_first ? {1'b0, bias} : 2'b10;
                end
                pend_first = v && (b == 0);
                pend = v;
                if (v) b++;
                m_rec.push_back(r);
                m_v.push_back(v);
            end
            r = base(opsel);
            r.en_add = '1;
            r.mux1 = pend_first ? {1'b0, bias} : 2'b10;
            m_rec.push_back(r);
            m_v.push_back(1'($urandom_range(1)));
            if (mode) begin
                for (int k = 1; k < NP; k++) begin
                    lane = '0;
                    lane[k] = 1'b1;
                    r = base(opsel);
                    r.en_add = lane;
                    r.mux0 = 1'b1;
                    r.mux1 = 2'b10;
                    m_rec.push_back(r);
                    m_v.push_back(1'($urandom_range(1)));
                end
                r = base(opsel);
                r.en_acc = 1'b1;
                r.accs = (t == 0) ? {1'b0, bias} : 2'b10;
                m_rec.push_back(r);
                m_v.push_back(1'($urandom_range(1)));
                if (t == tiles - 1) begin
                    r = base(opsel);
                    r.outv = 1'b1;
                    r.done = 1'b1;
                    m_rec.push_back(r);
                    m_v.push_back(1'($urandom_range(1)));
                end
            end else begin
                r = base(opsel);
                r.outv = 1'b1;
                r.done = (t == tiles - 1);
                m_rec.push_back(r);
                m_v.push_back(1'($urandom_range(1)));
            end
        end
    endtask

    task automatic run_job(input bit mode, input int len, input int tiles, input bit opsel,
                           input bit bias, input int stall_pct, input int stall_at, input bit noise);
        build_job(mode, len, tiles, opsel, bias, stall_pct, stall_at);
        @(posedge clk); #1;
        cfg_start   = 1'b1;
        cfg_mode    = mode;
        cfg_len     = CW'(len);
        cfg_tiles   = CW'(tiles);
        cfg_opsel   = opsel;
        cfg_bias_en = bias;
        in_valid    = 1'($urandom_range(1));
        for (int c = 0; c < m_v.size(); c++) begin
            @(posedge clk); #1;
            if (c == 0) foreach (m_rec[i]) sb_q.push_back(m_rec[i]);
            cfg_start = noise && ($urandom_range(3) == 0);
            if (noise) begin
                cfg_mode    = 1'($urandom_range(1));
                cfg_len     = CW'($urandom_range(7));
                cfg_tiles   = CW'($urandom_range(7));
                cfg_opsel   = 1'($urandom_range(1));
                cfg_bias_en = 1'($urandom_range(1));
            end
            in_valid = m_v[c];
        end
        @(posedge clk); #1;
        cfg_start = 1'b0;
        in_valid  = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        fork
            monitor_loop();
        join_none
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", actual(), '0);
        rstn   = 1'b1;
        mon_en = 1'b1;

        run_job(1'b0, 3, 1, 1'b0, 1'b0, 0, -1, 1'b0);
        run_job(1'b1, 2, 2, 1'b1, 1'b0, 0, -1, 1'b0);
        run_job(1'b0, 3, 1, 1'b0, 1'b0, 0, 2, 1'b0);
        run_job(1'b1, 1, 1, 1'b0, 1'b1, 0, -1, 1'b0);
        run_job(1'b0, 0, 3, 1'b1, 1'b1, 0, -1, 1'b1);
        run_job(1'b1, 2, 0, 1'b0, 1'b0, 0, -1, 1'b1);
        run_job(1'b0, 3, 2, 1'b1, 1'b1, 0, -1, 1'b1);
        run_job(1'b1, 1, 3, 1'b0, 1'b1, 0, -1, 1'b1);

        // Asynchronous reset in the middle of REDUCE, then a clean restart.
        mon_en = 1'b0;
        @(posedge clk); #1;
        cfg_start = 1'b1; cfg_mode = 1'b1; cfg_len = 2; cfg_tiles = 1;
        cfg_opsel = 1'b1; cfg_bias_en = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (en_add !== 4'b0100 || add_mux0_sel !== 1'b1) begin
            errors++;
            $display("FAIL reduce_k2 en_add=%b mux0=%b want en_add=0100 mux0=1", en_add, add_mux0_sel);
        end
        rstn = 1'b0;
        #1;
        chk("reset_mid_job", actual(), '0);
        @(posedge clk); #1;
        chk("reset_held", actual(), '0);
        in_valid = 1'b0;
        rstn = 1'b1;
        sb_q.delete();
        mon_en = 1'b1;
        run_job(1'b1, 2, 1, 1'b0, 1'b1, 0, -1, 1'b0);

        for (int j = 0; j < 30; j++) begin
            run_job(1'($urandom_range(1)), $urandom_range(5), $urandom_range(3),
                    1'($urandom_range(1)), 1'($urandom_range(1)), $urandom_range(40),
                    -1, 1'($urandom_range(1)));
        end

        repeat (3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
